lcg_stim_gen: RTL and testbench



---
 rtl/stim_pkg.sv | 19 +
 rtl/lcg_step.sv | 11 +
 rtl/lcg_stim_gen.sv | 145 ++++++++++++++
 tb/tb_lcg_stim_gen.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/stim_pkg.sv
// Shared constants, FSM state type and the reference LCG step for the
// stimulus generator slice.
package stim_pkg;

    localparam logic [31:0] LCG_MULT = 32'h41C64E6D;
    localparam logic [31:0] LCG_INC  = 32'h3039;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        FILL    = 2'd1,
        PRESENT = 2'd2,
        DONE    = 2'd3
    } stim_state_t;

    function automatic logic [31:0] lcg_next(input logic [31:0] i_state);
        return i_state * LCG_MULT + LCG_INC;
    endfunction

endpackage

// File: rtl/lcg_step.sv
// One combinational step of the team LCG (state*LCG_MULT + LCG_INC mod 2^32).
module lcg_step
    import stim_pkg::*;
(
    input  logic [31:0] i_state,
    output logic [31:0] o_next
);

    assign o_next = lcg_next(i_state);

endmodule

// File: rtl/lcg_stim_gen.sv
// LCG-driven stimulus source: builds OUT_W-bit vectors from 32-bit LCG words,
// low chunk first, and hands them out over valid/ready. Optional LCG_PARALLEL_EN.
module lcg_stim_gen
    import stim_pkg::*;
#(
    parameter int unsigned OUT_W = 137
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [31:0]      seed,
    input  logic [31:0]      num_vec,
    output logic [OUT_W-1:0] vec_out,
    output logic             vec_valid,
    input  logic             vec_ready,
    output logic [31:0]      vec_idx,
    output logic             busy,
    output logic             done
);

    localparam int unsigned NCHUNK = (OUT_W + 31) / 32;

    stim_state_t      r_state;
    logic [31:0]      r_rng;
    logic [31:0]      r_num;
    logic [31:0]      r_idx;
    logic             r_valid;
    logic [OUT_W-1:0] r_vec_out;

    logic [31:0]      w_fill_rng;
    logic [OUT_W-1:0] w_fill_vec;
    logic             w_fill_last;
    logic             w_start_ok;

    assign w_start_ok = start && (r_state == IDLE || r_state == DONE);

`ifdef LCG_PARALLEL_EN
    // Whole vector in one FILL cycle: NCHUNK chained steps, top chunk truncated.
    logic [31:0]      w_chain [0:NCHUNK];
    logic [OUT_W-1:0] w_par;

    assign w_chain[0] = r_rng;

    for (genvar g = 0; g < NCHUNK; g++) begin : g_chain
        lcg_step u_step (
            .i_state (w_chain[g]),
            .o_next  (w_chain[g+1])
        );
        if (g == NCHUNK - 1) begin : g_top
            assign w_par[OUT_W-1:32*g] = w_chain[g+1][OUT_W-32*g-1:0];
        end else begin : g_mid
            assign w_par[32*g +: 32] = w_chain[g+1];
        end
    end

    assign w_fill_rng  = w_chain[NCHUNK];
    assign w_fill_vec  = w_par;
    assign w_fill_last = 1'b1;
`else
    localparam int unsigned ASM_W = NCHUNK * 32;
    localparam int unsigned KW    = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

    logic [KW-1:0]    r_k;
    logic [ASM_W-1:0] r_asm;
    logic [ASM_W-1:0] w_asm;
    logic [31:0]      w_next;

    lcg_step u_step (
        .i_state (r_rng),
        .o_next  (w_next)
    );

    // Splice the current chunk in combinationally so the last chunk reaches
    // vec_out in the same cycle it is generated.
    always_comb begin
        w_asm = r_asm;
        w_asm[32*int'(r_k) +: 32] = w_next;
    end

    assign w_fill_rng  = w_next;
    assign w_fill_vec  = w_asm[OUT_W-1:0];
    assign w_fill_last = (r_k == KW'(NCHUNK - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_k   <= '0;
            r_asm <= '0;
        end else if (w_start_ok) begin
            r_k <= '0;
        end else if (r_state == FILL) begin
            r_asm <= w_asm;
            r_k   <= w_fill_last ? '0 : r_k + KW'(1);
        end
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_rng     <= '0;
            r_num     <= '0;
            r_idx     <= '0;
            r_valid   <= 1'b0;
            r_vec_out <= '0;
        end else begin
            case (r_state)
                IDLE, DONE: begin
                    if (w_start_ok) begin
                        r_rng   <= seed;
                        r_num   <= num_vec;
                        r_idx   <= '0;
                        r_state <= (num_vec == '0) ? DONE : FILL;
                    end
                end
                FILL: begin
                    r_rng <= w_fill_rng;
                    if (w_fill_last) begin
                        r_vec_out <= w_fill_vec;
                        r_valid   <= 1'b1;
                        r_state   <= PRESENT;
                    end
                end
                PRESENT: begin
                    if (vec_ready) begin
                        r_valid <= 1'b0;
                        if (r_idx == r_num - 32'd1) begin
                            r_state <= DONE;
                        end else begin
                            r_idx   <= r_idx + 32'd1;
                            r_state <= FILL;
                        end
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign vec_out   = r_vec_out;
    assign vec_valid = r_valid;
    assign vec_idx   = r_idx;
    assign busy      = (r_state == FILL) || (r_state == PRESENT);
    assign done      = (r_state == DONE);

endmodule

// File: tb/tb_lcg_stim_gen.sv
// Scoreboard bench for lcg_stim_gen: a plain-arithmetic LCG model queues the
// expected vectors per run; a negedge monitor checks every presented vector.
module tb_lcg_stim_gen;

    localparam int unsigned OUT_W  = 137;
    localparam int unsigned NCHUNK = (OUT_W + 31) / 32;
`ifdef LCG_PARALLEL_EN
    localparam int unsigned LAT = 1;
`else
    localparam int unsigned LAT = NCHUNK;
`endif

    typedef struct {
        logic [OUT_W-1:0] vec;
        logic [31:0]      idx;
    } exp_t;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic [31:0]      seed = '0;
    logic [31:0]      num_vec = '0;
    logic [OUT_W-1:0] vec_out;
    logic             vec_valid;
    logic             vec_ready = 1'b0;
    logic [31:0]      vec_idx;
    logic             busy;
    logic             done;

    int   errors = 0;
    int   checks = 0;
    int   rmode  = 0;
    exp_t exp_q[$];

    lcg_stim_gen #(.OUT_W(OUT_W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .seed      (seed),
        .num_vec   (num_vec),
        .vec_out   (vec_out),
        .vec_valid (vec_valid),
        .vec_ready (vec_ready),
        .vec_idx   (vec_idx),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Reference: each vector is NCHUNK successive LCG words packed low-first.
    task automatic push_run(input logic [31:0] s0, input logic [31:0] n);
        logic [31:0]          s;
        logic [NCHUNK*32-1:0] w;
        exp_t                 e;
        s = s0;
        for (int unsigned v = 0; v < n; v++) begin
            w = '0;
            for (int unsigned c = 0; c < NCHUNK; c++) begin
                s = s * 32'h41C64E6D + 32'h3039;
                w[c*32 +: 32] = s;
            end
            e.vec = w[OUT_W-1:0];
            e.idx = v;
            exp_q.push_back(e);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && vec_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_vector: got idx %0d expected none", vec_idx);
            end else begin
                chk("vec_out", 256'(vec_out), 256'(exp_q[0].vec));
                chk("vec_idx", 256'(vec_idx), 256'(exp_q[0].idx));
                if (vec_ready) void'(exp_q.pop_front());
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rmode)
                0:       vec_ready = 1'b1;
                1:       vec_ready = ($urandom_range(0, 2) != 0);
                default: vec_ready = 1'b0;
            endcase
        end
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] n, input bit push);
        @(posedge clk);
        #1;
        seed    = s;
        num_vec = n;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        if (push) push_run(s, n);
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(posedge clk);
            #1;
            if (done) break;
        end
        chk("done_reached", 256'(done), 256'(1));
    endtask

    task automatic run_basic(input string tag);
        int cyc;
        rmode = 0;
        do_start(32'd0, 32'd1, 1'b1);
        cyc = 0;
        while (!vec_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk({tag, "_latency"}, 256'(cyc), 256'(LAT));
        chk({tag, "_chunk0"}, 256'(vec_out[31:0]), 256'(32'h00003039));
        chk({tag, "_chunk1"}, 256'(vec_out[63:32]), 256'(32'hD3DC167E));
        @(posedge clk);
        #1;
        chk({tag, "_done"}, 256'(done), 256'(1));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
    endtask

    initial begin
        int cyc;
        // Reset state
        #12;
        chk("rst_valid", 256'(vec_valid), 256'(0));
        chk("rst_vec", 256'(vec_out), 256'(0));
        chk("rst_idx", 256'(vec_idx), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        @(negedge clk);
        rst_n = 1'b1;

        run_basic("basic");

        // Long cross-check run with random backpressure
        rmode = 1;
        do_start(32'd2351240810, 32'd101, 1'b1);
        wait_done(20000);
        chk("xcheck_drained", 256'(exp_q.size()), 256'(0));

        // Backpressure: hold ready low 7 cycles with a vector presented
        rmode = 2;
        do_start($urandom, 32'd4, 1'b1);
        cyc = 0;
        while (!vec_valid && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("bp_valid", 256'(vec_valid), 256'(1));
        chk("bp_first_idx", 256'(vec_idx), 256'(0));
        repeat (7) @(posedge clk);
        #1;
        chk("bp_still_valid", 256'(vec_valid), 256'(1));
        rmode = 1;
        wait_done(2000);
        chk("bp_drained", 256'(exp_q.size()), 256'(0));
        chk("bp_last_idx", 256'(vec_idx), 256'(3));

        // Zero count
        rmode = 0;
        do_start($urandom, 32'd0, 1'b1);
        chk("zero_done", 256'(done), 256'(1));
        chk("zero_busy", 256'(busy), 256'(0));
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            chk("zero_no_valid", 256'(vec_valid), 256'(0));
        end

        // Start while busy is ignored
        rmode = 2;
        do_start($urandom, 32'd2, 1'b1);
        @(posedge clk);
        #1;
        seed    = 32'hDEADBEEF;
        num_vec = 32'd9;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        rmode = 1;
        wait_done(2000);
        chk("ign_drained", 256'(exp_q.size()), 256'(0));
        chk("ign_last_idx", 256'(vec_idx), 256'(1));

        // Asynchronous reset during FILL
        rmode = 0;
        do_start(32'h12345678, 32'd3, 1'b1);
        @(posedge clk);
        #1;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 256'(vec_valid), 256'(0));
        chk("arst_vec", 256'(vec_out), 256'(0));
        chk("arst_idx", 256'(vec_idx), 256'(0));
        chk("arst_busy", 256'(busy), 256'(0));
        chk("arst_done", 256'(done), 256'(0));
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;

        run_basic("after_rst");
        chk("final_drained", 256'(exp_q.size()), 256'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
